// File: rtl/pb_ram_arbiter_if.sv
//==============================================================================
// Module      : pb_ram_arbiter_if
// Description : Requester and RAM signal bundle for pb_ram_arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

interface pb_ram_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic              busy;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    // Requesters plus the RAM itself sit on the master side.
    modport master (
        output req0, we0, addr0, wdata0,
        input  ack0, rdata0,
        output req1, we1, addr1, wdata1,
        input  ack1, rdata1,
        input  busy, ram_en, ram_we, ram_addr, ram_din,
        output ram_dout
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        output ack0, rdata0,
        input  req1, we1, addr1, wdata1,
        output ack1, rdata1,
        output busy, ram_en, ram_we, ram_addr, ram_din,
        input  ram_dout
    );
endinterface

`default_nettype wire

// File: rtl/pb_ram_arbiter.sv
//==============================================================================
// Module      : pb_ram_arbiter
// Description : Two-requester arbiter for one shared single-port block RAM.
//               Round-robin by default; define ARB_FIXED_PRIO_EN to give
//               requester 0 fixed priority.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module pb_ram_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int RAM_LAT = 1
) (
    input  wire logic         clk,
    input  wire logic         reset,
    pb_ram_arbiter_if.slave   bus
);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_ACK   = 2'd3;

    localparam logic [1:0] c_LAT_M1 = 2'(RAM_LAT - 1);

    logic [1:0]        r_state;
    logic [1:0]        r_cnt;
    logic              r_sel;
    logic              r_ack0;
    logic              r_ack1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_din;
    logic              w_winner;
`ifndef ARB_FIXED_PRIO_EN
    logic              r_ptr;
`endif

    always_comb begin
`ifdef ARB_FIXED_PRIO_EN
        w_winner = ~bus.req0;
`else
        w_winner = (bus.req0 && bus.req1) ? r_ptr : bus.req1;
`endif
    end

    // ram_addr/ram_din double as the latched transaction fields; ram_we is
    // still valid in ISSUE and decides between the write and read paths.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_cnt      <= 2'd0;
            r_sel      <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_ram_en   <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
`ifndef ARB_FIXED_PRIO_EN
            r_ptr      <= 1'b0;
`endif
        end else begin
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        r_sel      <= w_winner;
`ifndef ARB_FIXED_PRIO_EN
                        r_ptr      <= ~w_winner;
`endif
                        r_ram_en   <= 1'b1;
                        r_ram_we   <= w_winner ? bus.we1    : bus.we0;
                        r_ram_addr <= w_winner ? bus.addr1  : bus.addr0;
                        r_ram_din  <= w_winner ? bus.wdata1 : bus.wdata0;
                        r_state    <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    if (r_ram_we) begin
                        r_ack0  <= ~r_sel;
                        r_ack1  <= r_sel;
                        r_state <= c_ACK;
                    end else begin
                        r_cnt   <= c_LAT_M1;
                        r_state <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        if (r_sel) begin
                            r_rdata1 <= bus.ram_dout;
                        end else begin
                            r_rdata0 <= bus.ram_dout;
                        end
                        r_ack0  <= ~r_sel;
                        r_ack1  <= r_sel;
                        r_state <= c_ACK;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = (r_state != c_IDLE);
    assign bus.ack0     = r_ack0;
    assign bus.ack1     = r_ack1;
    assign bus.rdata0   = r_rdata0;
    assign bus.rdata1   = r_rdata1;
    assign bus.ram_en   = r_ram_en;
    assign bus.ram_we   = r_ram_we;
    assign bus.ram_addr = r_ram_addr;
    assign bus.ram_din  = r_ram_din;
endmodule

`default_nettype wire

// File: tb/tb_pb_ram_arbiter.sv
//==============================================================================
// Module      : tb_pb_ram_arbiter
// Description : Directed self-checking bench for pb_ram_arbiter (RAM_LAT 1 and 2).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pb_ram_arbiter;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pb_ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus_a ();
    pb_ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus_b ();

    pb_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .RAM_LAT(1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    pb_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .RAM_LAT(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // RAM models: unwritten locations read back as addr ^ 0x3C.
    function automatic logic [7:0] dflt(input logic [7:0] a);
        return a ^ 8'h3C;
    endfunction

    logic [7:0]   mem_a [256];
    logic [7:0]   mem_b [256];
    logic [255:0] wr_a = '0;
    logic [255:0] wr_b = '0;
    logic [7:0]   pipe_a = '0;
    logic [7:0]   pipe_b0 = '0;
    logic [7:0]   pipe_b1 = '0;

    always @(posedge clk) begin
        if (bus_a.ram_en) begin
            if (bus_a.ram_we) begin
                mem_a[bus_a.ram_addr] <= bus_a.ram_din;
                wr_a[bus_a.ram_addr]  <= 1'b1;
            end else begin
                pipe_a <= wr_a[bus_a.ram_addr] ? mem_a[bus_a.ram_addr] : dflt(bus_a.ram_addr);
            end
        end
        if (bus_b.ram_en) begin
            if (bus_b.ram_we) begin
                mem_b[bus_b.ram_addr] <= bus_b.ram_din;
                wr_b[bus_b.ram_addr]  <= 1'b1;
            end else begin
                pipe_b0 <= wr_b[bus_b.ram_addr] ? mem_b[bus_b.ram_addr] : dflt(bus_b.ram_addr);
            end
        end
        pipe_b1 <= pipe_b0;
    end
    assign bus_a.ram_dout = pipe_a;
    assign bus_b.ram_dout = pipe_b1;

    typedef struct packed {
        logic       who;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_rd0 = 8'h00;
    logic [7:0] exp_rd1 = 8'h00;
    int         lat;
    logic       who;
    int         n_rr;
    logic       rr_who;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic w, input logic [7:0] d);
        exp_t e;
        e.who  = w;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input logic w);
        exp_t e;
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("ack_who", 64'(w), 64'(e.who));
            check("rdata", 64'(w ? bus_a.rdata1 : bus_a.rdata0), 64'(e.data));
        end
    endtask

    // Returns the number of falling edges until an ack appears (0 on timeout).
    task automatic wait_ack_a(input int max, output int l, output logic w);
        l = 0;
        w = 1'b0;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (bus_a.ack0 || bus_a.ack1) begin
                l = i;
                w = bus_a.ack1;
                check("ack_exclusive", 64'(bus_a.ack0 & bus_a.ack1), 64'd0);
                return;
            end
        end
    endtask

    task automatic wait_ack_b0(input int max, output int l);
        l = 0;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (bus_b.ack0) begin
                l = i;
                return;
            end
        end
    endtask

    function automatic logic [63:0] outs_a();
        return {bus_a.ack0, bus_a.ack1, bus_a.busy, bus_a.ram_en, bus_a.ram_we,
                bus_a.ram_addr, bus_a.ram_din, bus_a.rdata0, bus_a.rdata1};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.req0 = 0; bus_a.we0 = 0; bus_a.addr0 = 0; bus_a.wdata0 = 0;
        bus_a.req1 = 0; bus_a.we1 = 0; bus_a.addr1 = 0; bus_a.wdata1 = 0;
        bus_b.req0 = 0; bus_b.we0 = 0; bus_b.addr0 = 0; bus_b.wdata0 = 0;
        bus_b.req1 = 0; bus_b.we1 = 0; bus_b.addr1 = 0; bus_b.wdata1 = 0;

        repeat (3) @(negedge clk);
        check("reset_outs", outs_a(), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Write 0xA5 to 0x05 from requester 0
        bus_a.req0 = 1; bus_a.we0 = 1; bus_a.addr0 = 8'h05; bus_a.wdata0 = 8'hA5;
        push_exp(1'b0, exp_rd0);
        @(negedge clk);
        check("wr_issue", 64'({bus_a.ram_en, bus_a.ram_we, bus_a.ram_addr, bus_a.ram_din}),
              64'({1'b1, 1'b1, 8'h05, 8'hA5}));
        check("wr_busy", 64'(bus_a.busy), 64'd1);
        @(negedge clk);
        check("wr_ack", 64'({bus_a.ack0, bus_a.ack1, bus_a.ram_en}), 64'(3'b100));
        sb_pop(1'b0);
        bus_a.req0 = 0;
        @(negedge clk);
        check("wr_idle", 64'({bus_a.busy, bus_a.ack0}), 64'd0);

        // Read back 0x05
        bus_a.req0 = 1; bus_a.we0 = 0;
        exp_rd0 = 8'hA5;
        push_exp(1'b0, exp_rd0);
        wait_ack_a(10, lat, who);
        bus_a.req0 = 0;
        check("rd_latency", 64'(lat), 64'd3);
        sb_pop(who);
        @(negedge clk);

        // Requester 1 changes its inputs after grant
        bus_a.req1 = 1; bus_a.we1 = 0; bus_a.addr1 = 8'h10;
        exp_rd1 = dflt(8'h10);
        push_exp(1'b1, exp_rd1);
        @(negedge clk);
        bus_a.addr1 = 8'h20; bus_a.req1 = 0;
        check("latched_addr", 64'({bus_a.ram_en, bus_a.ram_addr}), 64'({1'b1, 8'h10}));
        wait_ack_a(10, lat, who);
        check("dropped_req_lat", 64'(lat), 64'd2);
        sb_pop(who);
        check("rdata0_kept", 64'(bus_a.rdata0), 64'(exp_rd0));
        @(negedge clk);

        // Contention from reset
        reset = 1'b1;
        bus_a.req0 = 1; bus_a.we0 = 0; bus_a.addr0 = 8'h01;
        bus_a.req1 = 1; bus_a.we1 = 0; bus_a.addr1 = 8'h02;
        sb.delete();
        exp_rd0 = 8'h00; exp_rd1 = 8'h00;
        @(negedge clk);
        check("reset_clears", outs_a(), 64'd0);
        reset = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
        n_rr = 10;
`else
        n_rr = 4;
`endif
        for (int i = 0; i < n_rr; i++) begin
`ifdef ARB_FIXED_PRIO_EN
            rr_who = 1'b0;
`else
            rr_who = i[0];
`endif
            if (rr_who) exp_rd1 = dflt(8'h02);
            else        exp_rd0 = dflt(8'h01);
            push_exp(rr_who, rr_who ? exp_rd1 : exp_rd0);
            wait_ack_a(10, lat, who);
            check("rr_ack_seen", 64'(lat != 0), 64'd1);
            sb_pop(who);
        end

        // Asynchronous reset mid-transaction
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_reset", outs_a(), 64'd0);
        bus_a.req0 = 0; bus_a.req1 = 0;
        sb.delete();
        exp_rd0 = 8'h00; exp_rd1 = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset during WAIT aborts the read
        bus_a.req1 = 1; bus_a.we1 = 0; bus_a.addr1 = 8'h30;
        @(negedge clk);
        @(negedge clk);
        check("in_wait_busy", 64'({bus_a.busy, bus_a.ram_en}), 64'(2'b10));
        reset = 1'b1;
        bus_a.req1 = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_ack_after_reset", 64'({bus_a.ack0, bus_a.ack1}), 64'd0);
        end
        reset = 1'b0;
        check("rdata1_zero", 64'(bus_a.rdata1), 64'd0);
        @(negedge clk);
        bus_a.req1 = 1; bus_a.addr1 = 8'h31;
        exp_rd1 = dflt(8'h31);
        push_exp(1'b1, exp_rd1);
        wait_ack_a(10, lat, who);
        bus_a.req1 = 0;
        check("post_reset_lat", 64'(lat), 64'd3);
        sb_pop(who);
        @(negedge clk);

        // RAM_LAT=2 instance
        bus_b.req0 = 1; bus_b.we0 = 0; bus_b.addr0 = 8'h44;
        wait_ack_b0(12, lat);
        bus_b.req0 = 0;
        check("lat2_read_lat", 64'(lat), 64'd4);
        check("lat2_read_data", 64'(bus_b.rdata0), 64'(dflt(8'h44)));
        @(negedge clk);
        bus_b.req0 = 1; bus_b.we0 = 1; bus_b.addr0 = 8'h45; bus_b.wdata0 = 8'h9E;
        wait_ack_b0(12, lat);
        bus_b.req0 = 0;
        check("lat2_write_lat", 64'(lat), 64'd2);
        check("lat2_write_keeps", 64'(bus_b.rdata0), 64'(dflt(8'h44)));
        @(negedge clk);
        bus_b.req0 = 1; bus_b.we0 = 0;
        wait_ack_b0(12, lat);
        bus_b.req0 = 0;
        check("lat2_rb_lat", 64'(lat), 64'd4);
        check("lat2_rb_data", 64'(bus_b.rdata0), 64'h9E);
        check("lat2_no_ack1", 64'(bus_b.ack1), 64'd0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
